// File: rtl/audio_pkg.sv
// Shared sound-code and event-index constants for the audio event path.
package audio_pkg;

   // Sound codes as seen by the audio player; 0 means "nothing to play".
   localparam int SND_SILENCE = 0;
   localparam int SND_WALL    = 1;
   localparam int SND_PLATE   = 2;
   localparam int SND_GROUND  = 3;

   // Event line indices on event_in / event_en. Lower index = higher priority.
   localparam int EV_WALL   = 0;
   localparam int EV_PLATE  = 1;
   localparam int EV_GROUND = 2;

   // Event line i plays sound code i+1, so code 0 stays free for silence.
   function automatic int ev_to_code(input int idx);
      return idx + SND_WALL;
   endfunction

endpackage

// File: rtl/audio_code_fifo.sv
// Small synchronous FIFO of sound codes. Pointers wrap naturally; occupancy is
// a separate 0..DEPTH counter so full and empty never need pointer tricks.
// A push while full is accepted only when a pop happens in the same cycle.
module audio_code_fifo
   import audio_pkg::*;
#(
   parameter int CODE_W = 4,
   parameter int DEPTH  = 4,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [CODE_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level,
   output logic [CODE_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [CODE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign level   = count;
   assign head    = empty ? CODE_W'(SND_SILENCE) : mem[rd_ptr];

   // Storage array; contents are only observed through head when non-empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/audio_event_queue.sv
// Turns game-event lines into a queue of sound codes for the audio player.
// Rising edges of enabled event lines set a pending bit; one pending event per
// cycle is moved into the code FIFO, lowest index first (wall > plate > ground).
//
// Handshake: Data_ready is the valid of the head code on sound_code and
// Data_request is the player's ready; a code is transferred on every rising
// clk edge where both are high, and sound_code/Data_ready never depend
// combinationally on Data_request.
module audio_event_queue
   import audio_pkg::*;
#(
   parameter int NUM_EVENTS  = 3,
   parameter int CODE_W      = 4,
   parameter int DEPTH       = 4,
   parameter int DROP_NEWEST = 1,
   parameter int CNT_W       = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_EVENTS-1:0]       event_in,
   input  logic [NUM_EVENTS-1:0]       event_en,
   input  logic                        Data_request,
   output logic                        Data_ready,
   output logic [CODE_W-1:0]           sound_code,
   output logic [$clog2(DEPTH):0]      fifo_level,
   output logic [CNT_W-1:0]            drop_count,
   output logic [NUM_EVENTS-1:0]       dbg_pending
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [NUM_EVENTS-1:0] prev;
   logic [NUM_EVENTS-1:0] pending;
   logic [NUM_EVENTS-1:0] rise;
   logic [NUM_EVENTS-1:0] win_onehot;
   logic [NUM_EVENTS-1:0] clear_mask;
   logic                  win_valid;
   logic [CODE_W-1:0]     win_code;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // Only enabled 0->1 transitions create an event; a level held high counts once.
   assign rise = event_in & ~prev & event_en;

   // Isolate the lowest set pending bit: that event wins this cycle.
   assign win_onehot = pending & (~pending + NUM_EVENTS'(1));
   assign win_valid  = |pending;

   // Translate the winning one-hot pending bit into its sound code.
   always_comb begin
      win_code = CODE_W'(SND_SILENCE);
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (win_onehot[i]) begin
            win_code = CODE_W'(ev_to_code(i));
         end
      end
   end

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign pop  = ~fifo_empty & Data_request;
   assign push = win_valid & (~fifo_full | pop);
   assign drop = win_valid & fifo_full & ~pop & (DROP_NEWEST != 0);

   // The winner leaves the pending set when it is queued or dropped; in hold
   // mode it stays set and is retried on the next cycle.
   assign clear_mask = (push | drop) ? win_onehot : '0;

   // Edge history and pending set; a rise on an already pending bit merges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev    <= '0;
         pending <= '0;
      end else begin
         prev    <= event_in;
         pending <= (pending & ~clear_mask) | rise;
      end
   end

   // Saturating count of events discarded on overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
         drop_count <= drop_count + CNT_W'(1);
      end
   end

   audio_code_fifo #(
      .CODE_W (CODE_W),
      .DEPTH  (DEPTH),
      .LVL_W  (LVL_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (win_code),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level),
      .head  (sound_code)
   );

   assign Data_ready  = ~fifo_empty;
   assign dbg_pending = pending;

endmodule

// File: tb/tb_audio_event_queue.sv
// Bench for audio_event_queue: one instance per overflow mode, driven with the
// same stimulus and checked against a queue-based reference model.
module tb_audio_event_queue;

  localparam int NUM_EV = 3;
  localparam int CODE_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int LVL_W  = 3;
  localparam int CNT_MAX = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [NUM_EV-1:0] event_in;
  logic [NUM_EV-1:0] event_en;
  logic Data_request;

  logic              dr_d, dr_h;
  logic [CODE_W-1:0] code_d, code_h;
  logic [LVL_W-1:0]  lvl_d, lvl_h;
  logic [CNT_W-1:0]  cnt_d, cnt_h;
  logic [NUM_EV-1:0] pend_d, pend_h;

  always #5 clk = ~clk;

  audio_event_queue #(.NUM_EVENTS(3), .CODE_W(4), .DEPTH(4), .DROP_NEWEST(1), .CNT_W(8)) dut_drop (
    .clk(clk), .reset(reset), .event_in(event_in), .event_en(event_en),
    .Data_request(Data_request), .Data_ready(dr_d), .sound_code(code_d),
    .fifo_level(lvl_d), .drop_count(cnt_d), .dbg_pending(pend_d));

  audio_event_queue #(.NUM_EVENTS(3), .CODE_W(4), .DEPTH(4), .DROP_NEWEST(0), .CNT_W(8)) dut_hold (
    .clk(clk), .reset(reset), .event_in(event_in), .event_en(event_en),
    .Data_request(Data_request), .Data_ready(dr_h), .sound_code(code_h),
    .fifo_level(lvl_h), .drop_count(cnt_h), .dbg_pending(pend_h));

  // ---------------- scoreboard / reference model ----------------
  int n_total = 0;
  int n_bad   = 0;

  logic [CODE_W-1:0] exp_q[$];       // drop-newest instance
  logic [CODE_W-1:0] exp_q_hold[$];  // hold instance
  bit m_pend[2][NUM_EV];
  bit m_prev[NUM_EV];
  int m_cnt[2];
  int pop_hist[16];
  int pop_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_word(input int m);
    int w = 0;
    for (int i = 0; i < NUM_EV; i++) if (m_pend[m][i]) w += (1 << i);
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q_hold.delete();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      for (int i = 0; i < NUM_EV; i++) m_pend[m][i] = 1'b0;
    end
    for (int i = 0; i < NUM_EV; i++) m_prev[i] = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs currently applied.
  task automatic model_edge();
    bit rise[NUM_EV];
    int len;
    int w;
    for (int i = 0; i < NUM_EV; i++)
      rise[i] = event_in[i] && !m_prev[i] && event_en[i];
    for (int m = 0; m < 2; m++) begin
      len = (m == 0) ? exp_q.size() : exp_q_hold.size();
      if (len > 0 && Data_request) begin
        if (m == 0) void'(exp_q.pop_front());
        else        void'(exp_q_hold.pop_front());
        len--;
      end
      w = -1;
      for (int i = NUM_EV - 1; i >= 0; i--) if (m_pend[m][i]) w = i;
      if (w >= 0) begin
        if (len < DEPTH) begin
          if (m == 0) exp_q.push_back(CODE_W'(w + 1));
          else        exp_q_hold.push_back(CODE_W'(w + 1));
          m_pend[m][w] = 1'b0;
        end else if (m == 0) begin
          m_pend[m][w] = 1'b0;
          if (m_cnt[m] < CNT_MAX) m_cnt[m]++;
        end
      end
      for (int i = 0; i < NUM_EV; i++) if (rise[i]) m_pend[m][i] = 1'b1;
    end
    for (int i = 0; i < NUM_EV; i++) m_prev[i] = event_in[i];
  endtask

  task automatic sb_check();
    chk("drop_ready", int'(dr_d),   (exp_q.size() > 0) ? 1 : 0);
    chk("drop_code",  int'(code_d), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
    chk("drop_level", int'(lvl_d),  exp_q.size());
    chk("drop_count", int'(cnt_d),  m_cnt[0]);
    chk("drop_pend",  int'(pend_d), pend_word(0));
    chk("hold_ready", int'(dr_h),   (exp_q_hold.size() > 0) ? 1 : 0);
    chk("hold_code",  int'(code_h), (exp_q_hold.size() > 0) ? int'(exp_q_hold[0]) : 0);
    chk("hold_level", int'(lvl_h),  exp_q_hold.size());
    chk("hold_count", int'(cnt_h),  m_cnt[1]);
    chk("hold_pend",  int'(pend_h), pend_word(1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (dr_d && Data_request) begin
      pop_hist[code_d]++;
      pop_total++;
    end
    model_edge();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    event_in = '0;
    event_en = '1;
    Data_request = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) pop_hist[i] = 0;
    pop_total = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NUM_EV-1:0] ev;
    logic [NUM_EV-1:0] en;
    logic              req;
    logic              rdy;
    logic [CODE_W-1:0] code;
    logic [LVL_W-1:0]  lvl;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int req_pct;

    vecs[0]  = '{3'b111, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0};
    vecs[1]  = '{3'b000, 3'b111, 1'b0, 1'b1, 4'd1, 3'd1};
    vecs[2]  = '{3'b000, 3'b111, 1'b0, 1'b1, 4'd1, 3'd2};
    vecs[3]  = '{3'b000, 3'b111, 1'b0, 1'b1, 4'd1, 3'd3};
    vecs[4]  = '{3'b000, 3'b111, 1'b1, 1'b1, 4'd2, 3'd2};
    vecs[5]  = '{3'b000, 3'b111, 1'b1, 1'b1, 4'd3, 3'd1};
    vecs[6]  = '{3'b000, 3'b111, 1'b1, 1'b0, 4'd0, 3'd0};
    vecs[7]  = '{3'b001, 3'b110, 1'b1, 1'b0, 4'd0, 3'd0};
    vecs[8]  = '{3'b000, 3'b110, 1'b1, 1'b0, 4'd0, 3'd0};
    vecs[9]  = '{3'b000, 3'b111, 1'b1, 1'b0, 4'd0, 3'd0};
    vecs[10] = '{3'b010, 3'b111, 1'b1, 1'b0, 4'd0, 3'd0};
    vecs[11] = '{3'b000, 3'b111, 1'b1, 1'b1, 4'd2, 3'd1};
    vecs[12] = '{3'b000, 3'b111, 1'b1, 1'b0, 4'd0, 3'd0};

    // Reset state, checked both while held and right after release.
    reset = 1'b0;
    event_in = '0;
    event_en = '1;
    Data_request = 1'b0;
    model_reset();
    clear_hist();
    #12;
    chk("rst_ready", int'(dr_d), 0);
    chk("rst_level", int'(lvl_d), 0);
    do_reset();
    sb_check();

    // Single event with the player ready: two-cycle latency, one-cycle valid.
    event_in = 3'b001;
    Data_request = 1'b1;
    step();
    chk("t1_ready_k", int'(dr_d), 0);
    event_in = 3'b000;
    step();
    chk("t1_ready", int'(dr_d), 1);
    chk("t1_code", int'(code_d), 1);
    step();
    chk("t1_ready_after", int'(dr_d), 0);
    chk("t1_code_after", int'(code_d), 0);

    // Simultaneous events, backpressure, drain order, masking, level event.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      event_in = vecs[i].ev;
      event_en = vecs[i].en;
      Data_request = vecs[i].req;
      step();
      chk($sformatf("vec%0d_ready", i), int'(dr_d), int'(vecs[i].rdy));
      chk($sformatf("vec%0d_code", i), int'(code_d), int'(vecs[i].code));
      chk($sformatf("vec%0d_level", i), int'(lvl_d), int'(vecs[i].lvl));
      chk($sformatf("vec%0d_hold_level", i), int'(lvl_h), int'(vecs[i].lvl));
    end

    // A level held high for 20 cycles yields exactly one code 2.
    do_reset();
    clear_hist();
    Data_request = 1'b1;
    event_in = 3'b010;
    repeat (20) step();
    event_in = 3'b000;
    repeat (4) step();
    chk("level_code2_pops", pop_hist[2], 1);
    chk("level_total_pops", pop_total, 1);

    // Six separate rises of bit 2 with the player stalled: overflow behaviour.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      event_in = 3'b100;
      step();
      event_in = 3'b000;
      step();
    end
    repeat (2) step();
    chk("ovf_drop_level", int'(lvl_d), 4);
    chk("ovf_drop_count", int'(cnt_d), 2);
    chk("ovf_hold_level", int'(lvl_h), 4);
    chk("ovf_hold_count", int'(cnt_h), 0);
    chk("ovf_hold_pend", int'(pend_h), 4);
    chk("ovf_drop_pend", int'(pend_d), 0);
    // One pop: the held event takes the freed slot on that same edge.
    Data_request = 1'b1;
    step();
    Data_request = 1'b0;
    chk("pop_drop_level", int'(lvl_d), 3);
    chk("pop_hold_level", int'(lvl_h), 4);
    chk("pop_hold_pend", int'(pend_h), 0);
    step();
    chk("pop_hold_level2", int'(lvl_h), 4);

    // Asynchronous reset between edges clears everything immediately.
    #3;
    reset = 1'b0;
    #1;
    chk("arst_drop_ready", int'(dr_d), 0);
    chk("arst_drop_level", int'(lvl_d), 0);
    chk("arst_drop_count", int'(cnt_d), 0);
    chk("arst_hold_level", int'(lvl_h), 0);
    chk("arst_hold_pend", int'(pend_h), 0);
    #2;
    reset = 1'b1;
    model_reset();
    clear_hist();
    Data_request = 1'b1;
    repeat (6) step();
    chk("arst_no_stale", pop_total, 0);

    // Drop counter saturates at all-ones.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      event_in = 3'b001;
      step();
      event_in = 3'b000;
      step();
    end
    chk("sat_count", int'(cnt_d), CNT_MAX);
    chk("sat_hold_count", int'(cnt_h), 0);

    // Randomized traffic against the reference model.
    do_reset();
    req_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) req_pct = $urandom_range(5, 95);
      if (c == 1500) do_reset();
      for (int i = 0; i < NUM_EV; i++)
        if ($urandom_range(0, 99) < 30) event_in[i] = ~event_in[i];
      event_en = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      Data_request = ($urandom_range(0, 99) < req_pct);
      step();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
